// File: rtl/contador_checker.sv
// Receive-side checker for a ping-pong up/down counter stream: lock, direction, peak/trough, period, errors.
// Build option: define CONTADOR_CHECKER_RELOCK_EN to re-acquire after a tracking mismatch instead of faulting.
module contador_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               locked,
  output logic               dir,
  output logic               peak,
  output logic               trough,
  output logic               period_vld,
  output logic [WIDTH+1:0]   period_len,
  output logic               err,
  output logic [7:0]         err_count
);

  localparam logic [WIDTH-1:0] MAX_V    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH+1:0] CNT_ZERO = {(WIDTH+2){1'b0}};
  localparam logic [WIDTH+1:0] CNT_ONE  = {{(WIDTH+1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_V   = 4'(LOCK_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_TRACK, ST_FAULT} state_t;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_prev, w_prev_nxt;
  logic [3:0]         r_run, w_run_nxt;
  logic               r_dir, w_dir_nxt;
  logic               r_locked, w_locked_nxt;
  logic               r_peak, w_peak_nxt;
  logic               r_trough, w_trough_nxt;
  logic               r_pvld, w_pvld_nxt;
  logic [WIDTH+1:0]   r_plen, w_plen_nxt;
  logic               r_err, w_err_nxt;
  logic [7:0]         r_errcnt, w_errcnt_nxt;
  logic [WIDTH+1:0]   r_cnt, w_cnt_nxt;
  logic               r_seen_trough, w_seen_trough_nxt;
  logic [WIDTH-1:0]   w_expected;
  logic               w_exp_dir;
  logic               w_good;
  logic               w_match;
  logic [WIDTH+1:0]   w_cnt_inc;

  // A single step of magnitude one, with no wrap through MAX/0.
  function automatic logic f_good_step(input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] data);
    logic [WIDTH-1:0] up_v;
    logic [WIDTH-1:0] dn_v;
    up_v = prev + ONE_V;
    dn_v = prev - ONE_V;
    return ((data == up_v) && (prev != MAX_V)) || ((data == dn_v) && (prev != ZERO_V));
  endfunction

  function automatic logic [WIDTH-1:0] f_expected(input logic [WIDTH-1:0] prev, input logic d);
    logic [WIDTH-1:0] res_v;
    if (!d) begin
      res_v = (prev == MAX_V) ? (prev - ONE_V) : (prev + ONE_V);
    end else begin
      res_v = (prev == ZERO_V) ? (prev + ONE_V) : (prev - ONE_V);
    end
    return res_v;
  endfunction

  function automatic logic f_expected_dir(input logic [WIDTH-1:0] prev, input logic d);
    logic res_v;
    if (!d) begin
      res_v = (prev == MAX_V);
    end else begin
      res_v = (prev != ZERO_V);
    end
    return res_v;
  endfunction

  assign w_expected = f_expected(r_prev, r_dir);
  assign w_exp_dir  = f_expected_dir(r_prev, r_dir);
  assign w_good     = f_good_step(r_prev, in_data);
  assign w_match    = (in_data == w_expected);
  assign w_cnt_inc  = r_cnt + CNT_ONE;

  assign locked     = r_locked;
  assign dir        = r_dir;
  assign peak       = r_peak;
  assign trough     = r_trough;
  assign period_vld = r_pvld;
  assign period_len = r_plen;
  assign err        = r_err;
  assign err_count  = r_errcnt;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_prev        <= ZERO_V;
      r_run         <= 4'd0;
      r_dir         <= 1'b0;
      r_locked      <= 1'b0;
      r_peak        <= 1'b0;
      r_trough      <= 1'b0;
      r_pvld        <= 1'b0;
      r_plen        <= CNT_ZERO;
      r_err         <= 1'b0;
      r_errcnt      <= 8'd0;
      r_cnt         <= CNT_ZERO;
      r_seen_trough <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_prev        <= w_prev_nxt;
      r_run         <= w_run_nxt;
      r_dir         <= w_dir_nxt;
      r_locked      <= w_locked_nxt;
      r_peak        <= w_peak_nxt;
      r_trough      <= w_trough_nxt;
      r_pvld        <= w_pvld_nxt;
      r_plen        <= w_plen_nxt;
      r_err         <= w_err_nxt;
      r_errcnt      <= w_errcnt_nxt;
      r_cnt         <= w_cnt_nxt;
      r_seen_trough <= w_seen_trough_nxt;
    end
  end

  // Next-state and next-output logic; event pulses default low every cycle.
  always_comb begin
    w_state_nxt       = r_state;
    w_prev_nxt        = r_prev;
    w_run_nxt         = r_run;
    w_dir_nxt         = r_dir;
    w_locked_nxt      = r_locked;
    w_peak_nxt        = 1'b0;
    w_trough_nxt      = 1'b0;
    w_pvld_nxt        = 1'b0;
    w_plen_nxt        = r_plen;
    w_err_nxt         = 1'b0;
    w_errcnt_nxt      = r_errcnt;
    w_cnt_nxt         = r_cnt;
    w_seen_trough_nxt = r_seen_trough;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_prev_nxt  = in_data;
          w_run_nxt   = 4'd0;
          w_state_nxt = ST_ACQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_ACQ: begin
        if (in_valid) begin
          w_prev_nxt = in_data;
          if (r_run == 4'd0) begin
            if (w_good) begin
              w_dir_nxt = (in_data < r_prev);
              w_run_nxt = 4'd1;
            end else begin
              w_run_nxt = 4'd0;
            end
          end else begin
            if (w_match) begin
              w_dir_nxt = w_exp_dir;
              w_run_nxt = r_run + 4'd1;
            end else begin
              w_run_nxt = 4'd0;
            end
          end
          if (w_run_nxt == LOCK_V) begin
            w_state_nxt       = ST_TRACK;
            w_locked_nxt      = 1'b1;
            w_cnt_nxt         = CNT_ZERO;
            w_seen_trough_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_ACQ;
          end
        end else begin
          w_state_nxt = ST_ACQ;
        end
      end

      ST_TRACK: begin
        if (in_valid) begin
          w_prev_nxt = in_data;
          if (w_match) begin
            w_dir_nxt    = w_exp_dir;
            w_peak_nxt   = (in_data == MAX_V);
            w_trough_nxt = (in_data == ZERO_V);
            if (in_data == ZERO_V) begin
              // Period spans trough to trough, counting the closing trough sample.
              if (r_seen_trough) begin
                w_plen_nxt = w_cnt_inc;
                w_pvld_nxt = 1'b1;
              end else begin
                w_plen_nxt = r_plen;
              end
              w_cnt_nxt         = CNT_ZERO;
              w_seen_trough_nxt = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_err_nxt    = 1'b1;
            w_errcnt_nxt = (r_errcnt == 8'hFF) ? r_errcnt : (r_errcnt + 8'd1);
            w_locked_nxt = 1'b0;
`ifdef CONTADOR_CHECKER_RELOCK_EN
            w_run_nxt    = 4'd0;
            w_state_nxt  = ST_ACQ;
`else
            w_state_nxt  = ST_FAULT;
`endif
          end
        end else begin
          w_state_nxt = ST_TRACK;
        end
      end

      ST_FAULT: begin
        w_locked_nxt = 1'b0;
        w_state_nxt  = ST_FAULT;
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_locked_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_contador_checker.sv
// Directed self-checking bench for contador_checker (WIDTH=4, LOCK_LEN=4), both relock builds.
module tb_contador_checker;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic       locked;
  logic       dir;
  logic       peak;
  logic       trough;
  logic       period_vld;
  logic [5:0] period_len;
  logic       err;
  logic [7:0] err_count;

  int n_checks;
  int n_errors;

  contador_checker #(.WIDTH(4), .LOCK_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .locked     (locked),
    .dir        (dir),
    .peak       (peak),
    .trough     (trough),
    .period_vld (period_vld),
    .period_len (period_len),
    .err        (err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_seq(input int a, input int b);
    if (a <= b) begin
      for (int i = a; i <= b; i++) send(4'(i));
    end else begin
      for (int i = a; i >= b; i--) send(4'(i));
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    #2;
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_dir", {31'd0, dir}, 32'd0);
    check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
    check_eq("rst_period_len", {26'd0, period_len}, 32'd0);
    #10;
    rst = 1'b1;

    // Acquire from 0 upwards.
    run_seq(0, 3);
    check_eq("acq_not_locked", {31'd0, locked}, 32'd0);
    send(4'd4);
    check_eq("lock_locked", {31'd0, locked}, 32'd1);
    check_eq("lock_dir", {31'd0, dir}, 32'd0);
    check_eq("lock_err_count", {24'd0, err_count}, 32'd0);

    run_seq(5, 14);
    send(4'd15);
    check_eq("peak_pulse", {31'd0, peak}, 32'd1);
    check_eq("peak_no_trough", {31'd0, trough}, 32'd0);
    check_eq("peak_dir_still_up", {31'd0, dir}, 32'd0);
    send(4'd14);
    check_eq("peak_drop", {31'd0, peak}, 32'd0);
    check_eq("dir_down", {31'd0, dir}, 32'd1);
    check_eq("no_err", {31'd0, err}, 32'd0);

    run_seq(13, 1);
    send(4'd0);
    check_eq("first_trough", {31'd0, trough}, 32'd1);
    check_eq("first_trough_no_pvld", {31'd0, period_vld}, 32'd0);

    run_seq(1, 15);
    run_seq(14, 1);
    send(4'd0);
    check_eq("second_trough", {31'd0, trough}, 32'd1);
    check_eq("period_vld", {31'd0, period_vld}, 32'd1);
    check_eq("period_len", {26'd0, period_len}, 32'd30);
    send(4'd1);
    check_eq("pvld_drop", {31'd0, period_vld}, 32'd0);
    check_eq("trough_drop", {31'd0, trough}, 32'd0);
    idle_cycle();
    check_eq("idle_locked", {31'd0, locked}, 32'd1);
    check_eq("idle_period_len", {26'd0, period_len}, 32'd30);

    // Async reset mid-TRACK, between clock edges.
    run_seq(2, 15);
    run_seq(14, 13);
    check_eq("pre_rst_dir", {31'd0, dir}, 32'd1);
    check_eq("pre_rst_locked", {31'd0, locked}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("midrst_locked", {31'd0, locked}, 32'd0);
    check_eq("midrst_dir", {31'd0, dir}, 32'd0);
    check_eq("midrst_period_len", {26'd0, period_len}, 32'd0);
    check_eq("midrst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Wrap 15->0 in ACQ restarts the run.
    run_seq(14, 15);
    send(4'd0);
    check_eq("wrap_not_locked", {31'd0, locked}, 32'd0);
    run_seq(1, 3);
    check_eq("wrap_run3_not_locked", {31'd0, locked}, 32'd0);
    send(4'd4);
    check_eq("wrap_relock", {31'd0, locked}, 32'd1);
    check_eq("wrap_dir", {31'd0, dir}, 32'd0);

    // Inject 11 where 9 is expected.
    run_seq(5, 15);
    run_seq(14, 10);
    send(4'd11);
    check_eq("mm_err", {31'd0, err}, 32'd1);
    check_eq("mm_err_count", {24'd0, err_count}, 32'd1);
    check_eq("mm_locked", {31'd0, locked}, 32'd0);
    check_eq("mm_no_peak", {31'd0, peak}, 32'd0);
    check_eq("mm_no_trough", {31'd0, trough}, 32'd0);
    send(4'd10);
    check_eq("post_mm_err_drop", {31'd0, err}, 32'd0);
    check_eq("post_mm_err_count", {24'd0, err_count}, 32'd1);
    check_eq("post_mm_locked", {31'd0, locked}, 32'd0);
    run_seq(9, 8);
`ifdef CONTADOR_CHECKER_RELOCK_EN
    check_eq("relock_not_yet", {31'd0, locked}, 32'd0);
    send(4'd7);
    check_eq("relock_at_7", {31'd0, locked}, 32'd1);
    send(4'd6);
    check_eq("relock_locked", {31'd0, locked}, 32'd1);
    check_eq("relock_dir", {31'd0, dir}, 32'd1);
    check_eq("relock_err_count", {24'd0, err_count}, 32'd1);
`else
    run_seq(7, 6);
    check_eq("fault_locked", {31'd0, locked}, 32'd0);
    check_eq("fault_err_count", {24'd0, err_count}, 32'd1);
    check_eq("fault_err", {31'd0, err}, 32'd0);
    send(4'd0);
    check_eq("fault_frozen", {24'd0, err_count}, 32'd1);
`endif

    #2;
    rst = 1'b0;
    #1;
    check_eq("final_rst_err_count", {24'd0, err_count}, 32'd0);
    check_eq("final_rst_locked", {31'd0, locked}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
